reg_bank: RTL and testbench

Parametrised register bank: the successor to the single 8-bit load register. It holds DEPTH registers of WIDTH bits each, with one write port and two combinational read ports. The write port also performs in-place clear, increment and decrement operations and flags wrap-around. It sits between the toy processor's control unit and ALU as the general-purpose register store.

---
 rtl/reg_bank_pkg.sv | 13 +
 rtl/reg_bank_next.sv | 33 +++
 rtl/reg_bank.sv | 74 +++++++
 tb/tb_reg_bank.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank: write-port op encodings and field width.
package reg_bank_pkg;

   localparam int OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_LOAD  = 2'b00,
      OP_CLEAR = 2'b01,
      OP_INC   = 2'b10,
      OP_DEC   = 2'b11
   } op_t;

endpackage

// File: rtl/reg_bank_next.sv
// Next-value and wrap computation for one register under a write-port op.
// Used by both the write path and the optional read bypass, so they always agree.
module reg_bank_next
   import reg_bank_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] cur,
   input  op_t              op,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] nxt,
   output logic             wrap
);

   always_comb begin
      nxt  = cur;
      wrap = 1'b0;
      case (op)
         OP_LOAD:  nxt = data;
         OP_CLEAR: nxt = '0;
         OP_INC: begin
            nxt  = cur + WIDTH'(1);
            wrap = &cur;
         end
         OP_DEC: begin
            nxt  = cur - WIDTH'(1);
            wrap = ~|cur;
         end
         default: nxt = cur;
      endcase
   end

endmodule

// File: rtl/reg_bank.sv
// DEPTH x WIDTH register bank: one load/clear/inc/dec write port, two combinational read ports.
// Define REG_BANK_BYPASS_EN to forward the pending write value to a read port addressing it.
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             We,
   input  logic [OP_W-1:0]  Op,
   input  logic [AW-1:0]    W_addr,
   input  logic [WIDTH-1:0] W_data,
   input  logic [AW-1:0]    Ra_addr,
   input  logic [AW-1:0]    Rb_addr,
   output logic [WIDTH-1:0] Ra_out,
   output logic [WIDTH-1:0] Rb_out,
   output logic             Wrap
);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [WIDTH-1:0] cur_val;
   logic [WIDTH-1:0] nxt_val;
   logic             nxt_wrap;
   logic             w_hit;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;

   // Non-power-of-two DEPTH leaves unused addresses; those never write and read as zero.
   assign w_hit = We && !Reset && (int'(W_addr) < DEPTH);

   always_comb begin
      cur_val = '0;
      if (int'(W_addr) < DEPTH) cur_val = regs[W_addr];
   end

   reg_bank_next #(.WIDTH(WIDTH)) u_next (
      .cur  (cur_val),
      .op   (op_t'(Op)),
      .data (W_data),
      .nxt  (nxt_val),
      .wrap (nxt_wrap)
   );

   always_ff @(posedge CLK) begin
      if (Reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
         Wrap <= 1'b0;
      end else begin
         Wrap <= 1'b0;
         if (w_hit) begin
            regs[W_addr] <= nxt_val;
            Wrap         <= nxt_wrap;
         end
      end
   end

   always_comb begin
      ra = '0;
      rb = '0;
      if (int'(Ra_addr) < DEPTH) ra = regs[Ra_addr];
      if (int'(Rb_addr) < DEPTH) rb = regs[Rb_addr];
`ifdef REG_BANK_BYPASS_EN
      if (w_hit && (Ra_addr == W_addr)) ra = nxt_val;
      if (w_hit && (Rb_addr == W_addr)) rb = nxt_val;
`endif
   end

   assign Ra_out = ra;
   assign Rb_out = rb;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank (DEPTH=5, WIDTH=8) against an arithmetic reference model.
// Follows REG_BANK_BYPASS_EN the same way as the design build.
module tb_reg_bank;

   localparam int WIDTH = 8;
   localparam int DEPTH = 5;
   localparam int AW    = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst;
   logic             we;
   logic [1:0]       op;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;
   logic [AW-1:0]    raddr;
   logic [AW-1:0]    rbaddr;
   logic [WIDTH-1:0] ra_out;
   logic [WIDTH-1:0] rb_out;
   logic             wrap;

   int total = 0;
   int passed = 0;

   int model [DEPTH];
   int model_wrap;

   reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
      .CLK     (clk),
      .Reset   (rst),
      .We      (we),
      .Op      (op),
      .W_addr  (waddr),
      .W_data  (wdata),
      .Ra_addr (raddr),
      .Rb_addr (rbaddr),
      .Ra_out  (ra_out),
      .Rb_out  (rb_out),
      .Wrap    (wrap)
   );

   always #5 clk = ~clk;

   function automatic int op_result(int v, int o, int d);
      case (o)
         0: return d;
         1: return 0;
         2: return (v + 1) % 256;
         default: return (v + 255) % 256;
      endcase
   endfunction

   function automatic int op_wraps(int v, int o);
      return ((o == 2 && v == 255) || (o == 3 && v == 0)) ? 1 : 0;
   endfunction

   function automatic int exp_read(int a);
      if (a >= DEPTH) return 0;
`ifdef REG_BANK_BYPASS_EN
      if (we && !rst && int'(waddr) < DEPTH && a == int'(waddr))
         return op_result(model[a], int'(op), int'(wdata));
`endif
      return model[a];
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
   endtask

   // Drive at negedge, check reads before the edge, update model at the edge, check Wrap after it.
   task automatic cycle(input logic r, input logic w, input int o, input int wa,
                        input int wd, input int a, input int b);
      @(negedge clk);
      rst = r; we = w; op = 2'(o); waddr = AW'(wa); wdata = WIDTH'(wd);
      raddr = AW'(a); rbaddr = AW'(b);
      #1;
      check("ra_out", int'(ra_out), exp_read(a));
      check("rb_out", int'(rb_out), exp_read(b));
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < DEPTH; i++) model[i] = 0;
         model_wrap = 0;
      end else begin
         model_wrap = 0;
         if (w && wa < DEPTH) begin
            model_wrap = op_wraps(model[wa], o);
            model[wa]  = op_result(model[wa], o, wd);
         end
      end
      #1;
      check("wrap", int'(wrap), model_wrap);
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; op = '0; waddr = '0; wdata = '0; raddr = '0; rbaddr = '0;
      repeat (2) @(posedge clk);
      for (int i = 0; i < DEPTH; i++) model[i] = 0;
      model_wrap = 0;
      #1;
      check("wrap_after_reset", int'(wrap), 0);

      // read every address, including the unused ones above DEPTH-1
      for (int a = 0; a < 8; a++) cycle(0, 0, 0, 0, 0, a, 7 - a);

      cycle(0, 1, 0, 1, 'hAA, 1, 2);
      cycle(0, 1, 0, 2, 'h55, 2, 1);
      cycle(0, 0, 0, 0, 0, 1, 2);
      check("r1_aa", int'(ra_out), 'hAA);
      check("r2_55", int'(rb_out), 'h55);
      cycle(0, 0, 0, 0, 0, 0, 3);

      cycle(0, 1, 0, 3, 'hFE, 3, 3);
      cycle(0, 1, 2, 3, 0, 3, 0);
      cycle(0, 1, 2, 3, 0, 3, 0);
      check("inc_wrap_pulse", int'(wrap), 1);
      cycle(0, 1, 3, 3, 0, 3, 3);
      check("dec_wrap_pulse", int'(wrap), 1);
      cycle(0, 0, 0, 0, 0, 3, 3);
      check("r3_ff", int'(ra_out), 'hFF);
      check("wrap_clears", int'(wrap), 0);

      cycle(0, 0, 0, 1, 'h11, 1, 2);
      cycle(0, 0, 1, 2, 'h33, 1, 2);
      cycle(0, 0, 2, 1, 'h11, 1, 2);

      cycle(0, 1, 0, 5, 'h99, 5, 0);
      cycle(0, 1, 2, 7, 0, 5, 6);
      cycle(0, 0, 0, 0, 0, 5, 0);

      cycle(1, 1, 0, 0, 'hCC, 0, 1);
      cycle(0, 1, 0, 0, 'h33, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1);
      check("r0_33", int'(ra_out), 'h33);

      cycle(0, 1, 0, 2, 'h77, 2, 2);
      cycle(0, 0, 0, 0, 0, 2, 2);
      check("r2_77", int'(ra_out), 'h77);

      for (int n = 0; n < 400; n++) begin
         int o, wa, va;
         o  = int'($urandom_range(0, 3));
         wa = int'($urandom_range(0, 7));
         va = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) :
              (($urandom_range(0, 1) == 0) ? 255 : 0);
         cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), o, wa, va,
               ($urandom_range(0, 1) == 0) ? wa : int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
